// File: rtl/ls_pkg.sv
// ls_pkg: shared constants, terminal-value helpers and the per-edge operation encoding.
package ls_pkg;
  localparam int LS_NIBBLE = 4;
  typedef enum logic [1:0] {OP_RESET, OP_LOAD, OP_COUNT, OP_HOLD} ls_cnt_op_t;
  function automatic logic [15:0] LS_ALL_ONES(input int w);
    return 16'hFFFF >> (16 - w);
  endfunction
  function automatic logic [15:0] LS_ZERO(input int w);
    return 16'h0000 & LS_ALL_ONES(w);
  endfunction
endpackage

// File: rtl/ls74161_if.sv
// ls74161_if: control/data bundle of one counter slice; dn exists only with LS74161_DOWN_EN.
interface ls74161_if #(parameter int WIDTH = 4);
  logic             load_n;
  logic             enp;
  logic             ent;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;
`ifdef LS74161_DOWN_EN
  logic             dn;
`endif
  modport master (
`ifdef LS74161_DOWN_EN
    output dn,
`endif
    output load_n, enp, ent, d, input q, rco);
  modport slave (
`ifdef LS74161_DOWN_EN
    input dn,
`endif
    input load_n, enp, ent, d, output q, rco);
endinterface

// File: rtl/ls74161_cell.sv
// ls74161_cell: one counter bit; toggles on count when every lower bit is at its terminal value.
module ls74161_cell
  import ls_pkg::*;
(
  input  logic       clk,
  input  ls_cnt_op_t i_op,
  input  logic       i_d,
  input  logic       i_t,
  input  logic       i_dn,
  output logic       o_q,
  output logic       o_t
);
  logic r_q;
  always_ff @(posedge clk)
    r_q <= i_op == OP_RESET ? 1'b0 :
           i_op == OP_LOAD ? i_d :
           (i_op == OP_COUNT && i_t) ? ~r_q : r_q;
  // carry chain: up passes on ones, down passes on zeros
  assign o_q = r_q;
  assign o_t = i_t & (r_q ^ i_dn);
endmodule

// File: rtl/ls74161.sv
// ls74161: synchronous presettable binary counter slice with ripple-carry output.
// Define LS74161_DOWN_EN to add the dn (count down) input.
module ls74161
  import ls_pkg::*;
#(
  parameter int WIDTH = LS_NIBBLE
) (
  input logic     clk,
  input logic     rst,
  ls74161_if.slave bus
);
  ls_cnt_op_t       w_op;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_q;
  logic             w_dn;
`ifdef LS74161_DOWN_EN
  assign w_dn = bus.dn;
`else
  assign w_dn = 1'b0;
`endif
  always_comb
    w_op = rst ? OP_RESET : !bus.load_n ? OP_LOAD : (bus.enp && bus.ent) ? OP_COUNT : OP_HOLD;
  assign w_t[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ls74161_cell u_cell (
      .clk  (clk),
      .i_op (w_op),
      .i_d  (bus.d[i]),
      .i_t  (w_t[i]),
      .i_dn (w_dn),
      .o_q  (w_q[i]),
      .o_t  (w_t[i+1])
    );
  end
  assign bus.q   = w_q;
  assign bus.rco = bus.ent & w_t[WIDTH];
endmodule
